// File: rtl/risc8_uart_io.sv
// rtl/risc8_uart_io.sv - IO-mapped UART with TX/RX FIFOs, baud divisor, sticky errors and irq
// Optional RX path (synchroniser, receiver, RX FIFO) is built when RISC8_UART_RX_EN is defined.
module risc8_uart_io #(
  parameter logic [6:0] BASE       = 7'h2C,
  parameter int         DEPTH_LOG2 = 3,
  parameter int         DIVW       = 16,
  parameter int         BAUD_RESET = 51
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] io_addr,
  input  logic       io_wen,
  input  logic       io_ren,
  input  logic [7:0] io_wdata,
  output logic [7:0] io_rdata,
  output logic       io_hit,
  output logic       irq,
  output logic       serial_tx,
  input  logic       serial_rx
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
`ifdef RISC8_UART_RX_EN
  localparam logic RX_PRESENT = 1'b1;
`else
  localparam logic RX_PRESENT = 1'b0;
`endif

  logic [7:0]      off;
  logic            in_win, acc_w, acc_r;
  logic            wr_data, wr_stat, wr_lo, wr_hi, wr_ctrl;
  logic [7:0]      io_rdata_q, rdata_mux, status, baud_hi, rx_rdata;
  logic            io_hit_q, tx_drop_q;
  logic [DIVW-1:0] div_q;
  logic [2:0]      ctrl_q;
  logic            rx_ne, rx_full, frame_err, rx_overrun;

  assign off     = {1'b0, io_addr} - {1'b0, BASE};
  assign in_win  = (io_addr >= BASE) && (off < 8'd5);
  assign acc_w   = io_wen & in_win;
  assign acc_r   = io_ren & in_win;
  assign wr_data = acc_w && (off[2:0] == 3'd0);
  assign wr_stat = acc_w && (off[2:0] == 3'd1);
  assign wr_lo   = acc_w && (off[2:0] == 3'd2);
  assign wr_hi   = acc_w && (off[2:0] == 3'd3);
  assign wr_ctrl = acc_w && (off[2:0] == 3'd4);

  // TX FIFO and shifter
  logic [7:0]      tx_mem [DEPTH];
  logic [PW-1:0]   tx_wr_q, tx_rd_q;
  logic            tx_empty, tx_full, tx_push, tx_pop, tx_drop_set, tx_idle;
  logic            tx_busy_q, tx_q;
  logic [8:0]      tx_sh_q;
  logic [3:0]      tx_bit_q;
  logic [DIVW-1:0] tx_cnt_q;

  assign tx_empty    = (tx_wr_q == tx_rd_q);
  assign tx_full     = (tx_wr_q[DEPTH_LOG2-1:0] == tx_rd_q[DEPTH_LOG2-1:0]) &&
                       (tx_wr_q[PW-1] != tx_rd_q[PW-1]);
  // The shifter pops either when idle or exactly at the end of a stop bit, so frames abut.
  assign tx_pop      = !tx_empty && (!tx_busy_q || ((tx_cnt_q == '0) && (tx_bit_q == 4'd9)));
  assign tx_push     = wr_data && (!tx_full || tx_pop);
  assign tx_drop_set = wr_data && tx_full && !tx_pop;
  assign tx_idle     = tx_empty && !tx_busy_q;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_q[DEPTH_LOG2-1:0]] <= io_wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_busy_q <= 1'b0;
      tx_q      <= 1'b1;
      tx_sh_q   <= '1;
      tx_bit_q  <= '0;
      tx_cnt_q  <= '0;
      tx_rd_q   <= '0;
    end else if (tx_pop) begin
      tx_rd_q   <= tx_rd_q + 1'b1;
      tx_busy_q <= 1'b1;
      tx_q      <= 1'b0;
      tx_sh_q   <= {1'b1, tx_mem[tx_rd_q[DEPTH_LOG2-1:0]]};
      tx_bit_q  <= '0;
      tx_cnt_q  <= div_q;
    end else if (tx_busy_q) begin
      if (tx_cnt_q != '0) begin
        tx_cnt_q <= tx_cnt_q - 1'b1;
      end else if (tx_bit_q == 4'd9) begin
        tx_busy_q <= 1'b0;
        tx_q      <= 1'b1;
      end else begin
        tx_cnt_q <= div_q;
        tx_q     <= tx_sh_q[0];
        tx_sh_q  <= {1'b1, tx_sh_q[8:1]};
        tx_bit_q <= tx_bit_q + 1'b1;
      end
    end
  end

`ifdef RISC8_UART_RX_EN
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  rx_state_e       rx_state_q;
  logic            rx_s1_q, rx_s2_q, rx_s3_q, frame_err_q, rx_overrun_q;
  logic [7:0]      rx_sh_q;
  logic [2:0]      rx_bit_q;
  logic [DIVW-1:0] rx_cnt_q, rx_half, rx_half_load;
  logic [DIVW:0]   div_p1;
  logic [7:0]      rx_mem [DEPTH];
  logic [PW-1:0]   rx_wr_q, rx_rd_q;
  logic            rx_empty, rx_pop, rx_push, rx_done;

  assign div_p1       = {1'b0, div_q} + 1'b1;
  assign rx_half      = div_p1[DIVW:1];
  // The synchroniser already delays the edge by one clock, so the countdown starts one short.
  assign rx_half_load = (rx_half == '0) ? '0 : rx_half - 1'b1;
  assign rx_empty     = (rx_wr_q == rx_rd_q);
  assign rx_full      = (rx_wr_q[DEPTH_LOG2-1:0] == rx_rd_q[DEPTH_LOG2-1:0]) &&
                        (rx_wr_q[PW-1] != rx_rd_q[PW-1]);
  assign rx_ne        = !rx_empty;
  assign rx_pop       = acc_r && (off[2:0] == 3'd0) && !rx_empty;
  assign rx_done      = (rx_state_q == RX_STOP) && (rx_cnt_q == '0);
  assign rx_push      = rx_done && rx_s2_q && (!rx_full || rx_pop);
  assign rx_rdata     = rx_empty ? 8'h00 : rx_mem[rx_rd_q[DEPTH_LOG2-1:0]];
  assign frame_err    = frame_err_q;
  assign rx_overrun   = rx_overrun_q;

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_q[DEPTH_LOG2-1:0]] <= rx_sh_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_s3_q      <= 1'b1;
      rx_state_q   <= RX_IDLE;
      rx_sh_q      <= '0;
      rx_bit_q     <= '0;
      rx_cnt_q     <= '0;
      rx_wr_q      <= '0;
      rx_rd_q      <= '0;
      frame_err_q  <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      rx_s1_q <= serial_rx;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
      if (rx_push) rx_wr_q <= rx_wr_q + 1'b1;
      if (rx_pop)  rx_rd_q <= rx_rd_q + 1'b1;
      if (rx_done && !rx_s2_q)                 frame_err_q <= 1'b1;
      else if (wr_stat && io_wdata[4])         frame_err_q <= 1'b0;
      if (rx_done && rx_s2_q && rx_full && !rx_pop) rx_overrun_q <= 1'b1;
      else if (wr_stat && io_wdata[5])         rx_overrun_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: if (rx_s3_q && !rx_s2_q) begin
          rx_state_q <= RX_START;
          rx_cnt_q   <= rx_half_load;
        end
        RX_START: if (rx_cnt_q != '0) rx_cnt_q <= rx_cnt_q - 1'b1;
          else if (rx_s2_q) rx_state_q <= RX_IDLE;
          else begin
            rx_state_q <= RX_DATA;
            rx_cnt_q   <= div_q;
            rx_bit_q   <= '0;
          end
        RX_DATA: if (rx_cnt_q != '0) rx_cnt_q <= rx_cnt_q - 1'b1;
          else begin
            rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
            rx_bit_q <= rx_bit_q + 1'b1;
            rx_cnt_q <= div_q;
            if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
          end
        default: if (rx_cnt_q != '0) rx_cnt_q <= rx_cnt_q - 1'b1;
          else rx_state_q <= RX_IDLE;
      endcase
    end
  end
`else
  logic unused_rx;
  assign unused_rx  = serial_rx;
  assign rx_ne      = 1'b0;
  assign rx_full    = 1'b0;
  assign frame_err  = 1'b0;
  assign rx_overrun = 1'b0;
  assign rx_rdata   = 8'h00;
`endif

  assign status = {1'b0, tx_drop_q, rx_overrun, frame_err, rx_full, rx_ne, tx_idle, !tx_full};

  always_comb begin
    baud_hi = 8'h00;
    baud_hi[DIVW-9:0] = div_q[DIVW-1:8];
  end

  always_comb begin
    rdata_mux = 8'h00;
    case (off[2:0])
      3'd0:    rdata_mux = rx_rdata;
      3'd1:    rdata_mux = status;
      3'd2:    rdata_mux = div_q[7:0];
      3'd3:    rdata_mux = baud_hi;
      3'd4:    rdata_mux = {5'b00000, ctrl_q};
      default: rdata_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      io_rdata_q <= 8'h00;
      io_hit_q   <= 1'b0;
      div_q      <= DIVW'(BAUD_RESET);
      ctrl_q     <= 3'b000;
      tx_drop_q  <= 1'b0;
      tx_wr_q    <= '0;
    end else begin
      io_hit_q <= acc_w | acc_r;
      if (acc_r)   io_rdata_q <= rdata_mux;
      if (wr_lo)   div_q[7:0] <= io_wdata;
      if (wr_hi)   div_q[DIVW-1:8] <= io_wdata[DIVW-9:0];
      if (wr_ctrl) ctrl_q <= {io_wdata[2:1], io_wdata[0] & RX_PRESENT};
      if (tx_drop_set)                 tx_drop_q <= 1'b1;
      else if (wr_stat && io_wdata[6]) tx_drop_q <= 1'b0;
      if (tx_push) tx_wr_q <= tx_wr_q + 1'b1;
    end
  end

  assign io_rdata  = io_rdata_q;
  assign io_hit    = io_hit_q;
  assign serial_tx = tx_q;
  assign irq       = (ctrl_q[0] & rx_ne) | (ctrl_q[1] & tx_idle) |
                     (ctrl_q[2] & (frame_err | rx_overrun));
endmodule

// File: tb/tb_risc8_uart_io.sv
// tb/tb_risc8_uart_io.sv - self-checking bench for risc8_uart_io
// Serial output is decoded by a line monitor and compared against a queue of expected bytes.
module tb_risc8_uart_io;
  localparam logic [6:0] BASE   = 7'h2C;
  localparam logic [6:0] A_DATA = BASE;
  localparam logic [6:0] A_STAT = BASE + 7'd1;
  localparam logic [6:0] A_BLO  = BASE + 7'd2;
  localparam logic [6:0] A_BHI  = BASE + 7'd3;
  localparam logic [6:0] A_CTRL = BASE + 7'd4;
`ifdef RISC8_UART_RX_EN
  localparam logic [7:0] CTRL_ALL = 8'h07;
`else
  localparam logic [7:0] CTRL_ALL = 8'h06;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [6:0] io_addr = '0;
  logic       io_wen = 1'b0, io_ren = 1'b0;
  logic [7:0] io_wdata = '0;
  logic [7:0] io_rdata;
  logic       io_hit, irq, serial_tx, serial_rx;
  logic       rx_drv = 1'b1, loop_en = 1'b0;
  int         n_cmp = 0, n_err = 0;
  int         mon_div = 51;
  int         stop_errs = 0;
  logic [7:0] txq[$];

  assign serial_rx = loop_en ? serial_tx : rx_drv;

  risc8_uart_io dut (
    .clk(clk), .reset_n(reset_n), .io_addr(io_addr), .io_wen(io_wen), .io_ren(io_ren),
    .io_wdata(io_wdata), .io_rdata(io_rdata), .io_hit(io_hit), .irq(irq),
    .serial_tx(serial_tx), .serial_rx(serial_rx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    @(negedge clk); io_addr = a; io_wdata = d; io_wen = 1'b1;
    @(negedge clk); io_wen = 1'b0;
  endtask

  task automatic rd(input logic [6:0] a, output logic [7:0] d);
    @(negedge clk); io_addr = a; io_ren = 1'b1;
    @(negedge clk); io_ren = 1'b0; d = io_rdata;
  endtask

  task automatic wait_txq(input int n, input int budget);
    int c = 0;
    while (txq.size() < n && c < budget) begin @(negedge clk); c++; end
    check("txq_count", txq.size(), n);
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop, input int div);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); rx_drv = f[i];
      repeat (div) @(negedge clk);
    end
    @(negedge clk); rx_drv = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // Line monitor: detect start, sample each bit mid-period, record the byte.
  initial begin : tx_monitor
    logic [7:0] b;
    int p;
    forever begin
      @(negedge clk);
      if (reset_n && serial_tx === 1'b0) begin
        p = mon_div + 1;
        repeat (p / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin repeat (p) @(negedge clk); b[i] = serial_tx; end
        repeat (p) @(negedge clk);
        if (serial_tx !== 1'b1) stop_errs++;
        txq.push_back(b);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] d, b, exp_bit;
    logic [7:0] exp_q[$];
    int n, div;

    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", serial_tx, 1'b1);
    check("rst_hit", io_hit, 1'b0);
    check("rst_rdata", io_rdata, 8'h00);
    check("rst_irq", irq, 1'b0);
    reset_n = 1'b1;

    rd(A_STAT, d); check("rst_status", d, 8'h03);
    check("hit_after_read", io_hit, 1'b1);
    @(negedge clk); check("hit_one_cycle", io_hit, 1'b0);
    rd(A_BHI, d); check("rst_baud_hi", d, 8'h00);
    rd(A_BLO, d); check("rst_baud_lo", d, 8'h33);
    wr(BASE + 7'd5, 8'hFF); check("hit_off5", io_hit, 1'b0);
    rd(BASE - 7'd1, d); check("hit_below", io_hit, 1'b0);
    check("rdata_hold", d, 8'h33);
`ifndef RISC8_UART_RX_EN
    rd(A_DATA, d); check("data_read_norx", d, 8'h00);
`endif

    wr(A_CTRL, 8'hFF); rd(A_CTRL, d); check("ctrl_read", d, CTRL_ALL);
    check("irq_tx_idle", irq, 1'b1);
    wr(A_CTRL, 8'h02);

    // Single byte, divisor 3: 10 bits of 4 clocks each
    wr(A_BLO, 8'd3); mon_div = 3;
    wr(A_DATA, 8'hA5);
    check("tx_lat1", serial_tx, 1'b1);
    check("irq_busy", irq, 1'b0);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      n = k / 4;
      if (n == 0) exp_bit = 8'd0;
      else if (n == 9) exp_bit = 8'd1;
      else exp_bit = (8'hA5 >> (n - 1)) & 8'd1;
      check($sformatf("tx_bit%0d", k), serial_tx, exp_bit[0]);
    end
    @(negedge clk); check("tx_idle_40", irq, 1'b1);
    wait_txq(1, 50);
    if (txq.size() > 0) check("tx_a5", txq.pop_front(), 8'hA5);

    // Overflow: 10 writes back-to-back, 9 fit (FIFO plus one in the shifter)
    exp_q.delete(); txq.delete();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); io_addr = A_DATA; io_wen = 1'b1; io_wdata = 8'($urandom);
      if (i < 9) exp_q.push_back(io_wdata);
    end
    @(negedge clk); io_wen = 1'b0;
    rd(A_STAT, d); check("ovf_status", d, 8'h40);
    wr(A_STAT, 8'h40); rd(A_STAT, d); check("ovf_clear", d, 8'h00);
    wait_txq(9, 9 * 40 + 100);
    while (txq.size() > 0 && exp_q.size() > 0) check("ovf_byte", txq.pop_front(), exp_q.pop_front());

    // Random divisors and bursts that never overflow
    for (int r = 0; r < 3; r++) begin
      div = $urandom_range(1, 6);
      wr(A_BLO, 8'(div)); mon_div = div;
      n = $urandom_range(1, 8);
      exp_q.delete(); txq.delete();
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom); exp_q.push_back(b); wr(A_DATA, b);
      end
      wait_txq(n, n * 10 * (div + 1) + 100);
      while (txq.size() > 0 && exp_q.size() > 0) check("rnd_byte", txq.pop_front(), exp_q.pop_front());
      repeat (2 * (div + 1) + 4) @(negedge clk);
      rd(A_STAT, d); check("rnd_status", d, 8'h03);
    end
    check("stop_bits", stop_errs, 0);

    wr(A_BLO, 8'd3); mon_div = 3;
`ifdef RISC8_UART_RX_EN
    // Loopback
    wr(A_CTRL, 8'h01); loop_en = 1'b1;
    wr(A_DATA, 8'h3C);
    n = 0;
    while (irq !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    check("lb_irq_rise", irq, 1'b1);
    rd(A_DATA, d); check("lb_data", d, 8'h3C);
    check("lb_irq_fall", irq, 1'b0);
    repeat (10) @(negedge clk);
    loop_en = 1'b0; txq.delete();

    drive_frame(8'h55, 1'b0, 3);
    repeat (8) @(negedge clk);
    rd(A_STAT, d); check("frame_err", d, 8'h13);
    wr(A_STAT, 8'h10);

    exp_q.delete();
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom); if (i < 8) exp_q.push_back(b); drive_frame(b, 1'b1, 3);
    end
    repeat (8) @(negedge clk);
    rd(A_STAT, d); check("overrun_status", d, 8'h2F);
    for (int i = 0; i < 8; i++) begin rd(A_DATA, d); check("rx_byte", d, exp_q[i]); end
    rd(A_STAT, d); check("overrun_sticky", d, 8'h23);
    wr(A_STAT, 8'h20); rd(A_STAT, d); check("overrun_clear", d, 8'h03);

    @(negedge clk); rx_drv = 1'b0; @(negedge clk); rx_drv = 1'b1;
    repeat (60) @(negedge clk);
    rd(A_STAT, d); check("glitch", d, 8'h03);
`endif

    // Reset during TX bit 4 (byte 0x52 has bit 3 low)
    wr(A_DATA, 8'h52);
    wr(A_DATA, 8'h11);
    repeat (16) @(negedge clk);
    check("pre_reset_bit4", serial_tx, 1'b0);
    #1 reset_n = 1'b0;
    #1 check("reset_tx_async", serial_tx, 1'b1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rd(A_STAT, d); check("reset_status", d, 8'h03);
    rd(A_BLO, d); check("reset_baud", d, 8'h33);
    repeat (20) @(negedge clk);
    check("reset_tx_stays", serial_tx, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/risc8_uart_io.md
# risc8_uart_io

Parametrised IO-mapped UART peripheral for the risc8 SoC: a byte-wide register window on the core's IO address space, TX and RX FIFOs of configurable depth, a configurable-width baud divisor, sticky error flags, and a maskable interrupt. It sits beside the core's data port and drives `serial_tx` and samples `serial_rx`. The SoC muxes `io_rdata` onto the core's read bus whenever `io_hit` is set.

## Interface
- `BASE`, 7'h2C: IO address of register 0; the window is BASE..BASE+4.
- `DEPTH_LOG2`, 3: each FIFO holds 2**DEPTH_LOG2 bytes; minimum value is 1.
- `DIVW`, 16: baud divisor width, 9..16.
- `BAUD_RESET`, 51: divisor after reset; 6 MHz / 52 gives 115200 baud.

- `clk`  in  1  single clock; all state is updated on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `io_addr`  in  7  IO address.
- `io_wen`  in  1  write strobe, one cycle per access.
- `io_ren`  in  1  read strobe, one cycle per access.
- `io_wdata`  in  8  write data.
- `io_rdata`  out  8  registered read data.
- `io_hit`  out  1  registered; high for exactly one cycle after a decoded access.
- `irq`  out  1  level interrupt.
- `serial_tx`  out  1  TX line; idles high.
- `serial_rx`  in  1  RX line; asynchronous input.

## Operation
Register offsets from BASE:
- **+0 DATA:** write pushes a byte to the TX FIFO; read pops a byte from the RX FIFO. Reading an empty RX FIFO returns 0 and does not pop.
- **+1 STATUS:**
  - [0] tx_not_full, [1] tx_idle (TX FIFO empty and shifter idle), [2] rx_not_empty, [3] rx_full.
  - [4] frame_err, [5] rx_overrun, [6] tx_drop, [7] reads 0.
  - Bits 4–6 are sticky and write-1-to-clear; other written bits are ignored.
- **+2 BAUD_LO / +3 BAUD_HI:** divisor bits [7:0] and [DIVW-1:8]; unimplemented high bits read 0. One bit period is divisor+1 clocks. A new value takes effect at the next bit boundary.
- **+4 CTRL:** [0] rx irq enable, [1] tx_idle irq enable, [2] error irq enable; bits [7:3] read 0.
- Offsets 5–7 and addresses outside the window: no effect, `io_hit` stays low.

Interrupt: `irq = (CTRL[0] & rx_not_empty) | (CTRL[1] & tx_idle) | (CTRL[2] & (frame_err | rx_overrun))`, combinational from flops only.

TX path:
- Frame is 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
- When the shifter is idle and the TX FIFO is non-empty, the shifter pops a byte.
- Back-to-back frames have no idle gap.
- A write to a full TX FIFO is dropped and sets tx_drop. If the shifter pops in the same cycle as that write, the write is accepted instead.

RX path:
- `serial_rx` passes through a 2-flop synchroniser.
- States: IDLE → START → DATA → STOP.
  - IDLE → START on a synchronised falling edge.
  - START: the line is sampled (divisor+1)/2 clocks later, truncated. If the sample is high, the start was a glitch: return to IDLE.
  - DATA: sample 8 bits, each one full bit period after the previous sample.
  - STOP: sample once. A low stop bit sets frame_err and discards the byte. A byte arriving when the RX FIFO is full sets rx_overrun and is dropped.
- RX push and DATA pop in the same cycle on a full FIFO: both succeed.

FIFO pointers are DEPTH_LOG2+1 bits wide and wrap modulo 2**(DEPTH_LOG2+1). Full means the low bits are equal and the MSBs differ.

## Timing
- Read: with `io_ren` at cycle N, `io_rdata` and `io_hit` are valid at N+1. `io_rdata` holds its value until the next decoded read.
- Write: with `io_wen` at N, the register or FIFO is updated at N+1. STATUS at N+1 reflects the write.
- TX latency: DATA write at N with the shifter idle → `serial_tx` goes low at N+2. A frame lasts 10·(divisor+1) clocks.
- RX latency: rx_not_empty rises 1 cycle after the stop-bit sample. The stop-bit sample falls 2 + (divisor+1)/2 + 9·(divisor+1) clocks after the line edge.
- Reset values:
  - `serial_tx`=1, `io_rdata`=0, `io_hit`=0, `irq`=0.
  - FIFOs empty, divisor=BAUD_RESET, CTRL=0, sticky bits 0.
  - TX and RX state machines in idle.
- Reset asserted mid-frame aborts immediately and asynchronously: `serial_tx` goes high, and partial RX bytes are discarded.

## Configuration
- `RISC8_UART_RX_EN` defined: the full RX path, RX FIFO, STATUS bits [5:2] and CTRL bit 0 are present.
- Undefined:
  - No RX logic is generated and `serial_rx` is ignored.
  - DATA reads return 0, and STATUS[5:2] and CTRL[0] read 0.
  - `irq` has no RX term.
  - TX behaviour is unchanged.

## Test plan
- **Reset and register defaults:** release reset, read STATUS and BAUD.
  - STATUS = 8'h03, BAUD_LO = 8'h33, BAUD_HI = 8'h00, `serial_tx` = 1.
- **Single-byte TX:** divisor 3, write 8'hA5.
  - `serial_tx` goes low 2 cycles later, then 1,0,1,0,0,1,0,1 then 1, each bit 4 clocks.
  - tx_idle rises after 40 clocks.
- **TX overflow:** write 10 bytes back-to-back with DEPTH_LOG2=3.
  - 9 bytes are sent (8 in the FIFO plus 1 popped by the shifter); tx_drop is set.
  - Writing 8'h40 to STATUS clears tx_drop.
- **RX loopback:** `serial_tx` tied to `serial_rx`, CTRL = 1, send 8'h3C.
  - `irq` rises; DATA reads 8'h3C; `irq` falls.
- **RX errors (RX_EN defined):**
  - Drive a frame with stop bit 0 → frame_err = 1, FIFO stays empty.
  - Send 9 bytes without reading → rx_full, rx_overrun = 1, first 8 bytes read back intact.
- **Glitch and reset mid-frame:**
  - A 1-clock low pulse on `serial_rx` → no byte received.
  - `reset_n` low during TX bit 4 → `serial_tx` = 1 immediately and TX FIFO empty.
